alu_arb: RTL
============

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter RR_INIT, default 0, meaning: requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 offers an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_alucont  input  3  requester 0 ALU control code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_alucont: same as REQ-004..REQ-007, for requester 1.
REQ-009 rsp_valid  output  1  result register holds an undelivered result.
REQ-010 rsp_id  output  1  requester that owns the held result.
REQ-011 rsp_result  output  32  held ALU result.
REQ-012 rsp_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 Block SHALL share one ALU instance between two requesters through a single registered output stage.
REQ-014 ALU codes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-015 SLT SHALL return 1 when the 32-bit sign bit of a-b is set, else 0; overflow is ignored.
REQ-016 ADD and SUB SHALL wrap modulo 2^32.
REQ-017 Stage SHALL be free when rsp_valid=0 or rsp_ready=1 in the same cycle.
REQ-018 Grant SHALL occur only when the stage is free and at least one reqN_valid=1.
REQ-019 Grant with one requester valid: that requester wins.
REQ-020 Grant with both valid: the priority-pointer requester wins.
REQ-021 reqN_ready SHALL be 1 exactly when requester N is granted; at most one ready per cycle.
REQ-022 reqN_ready MAY depend combinationally on valids and rsp_ready; no register sits between them.
REQ-023 On grant, the winner's ALU result SHALL load rsp_result at the next edge; rsp_valid=1 and rsp_id=winner.
REQ-024 Latency SHALL be 1 cycle from acceptance to rsp_valid.
REQ-025 With rsp_ready held 1, throughput SHALL be one operation per cycle.
REQ-026 Simultaneous delivery and grant: new result SHALL replace the delivered one; rsp_valid stays 1.
REQ-027 Delivery without grant: rsp_valid SHALL go 0 next cycle.
REQ-028 While rsp_valid=1 and rsp_ready=0: rsp_result and rsp_id SHALL hold; both ready outputs SHALL be 0.
REQ-029 Priority pointer SHALL move to the non-winner after every grant, and hold when no grant occurs.
REQ-030 A requester SHALL hold valid and payload stable until accepted; the block does not check this.
REQ-031 Starvation bound: with both requesters continuously valid, neither SHALL wait more than one grant.

Reset
REQ-032 While reset=1: rsp_valid=0, rsp_id=0, rsp_result=0, priority pointer=RR_INIT.
REQ-033 While reset=1: req0_ready=0 and req1_ready=0; no grant occurs.
REQ-034 Reset asserted while a result is held or a grant is in progress SHALL discard that operation.
REQ-035 The first grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-036 ALU control-code constants (AND, OR, ADD, SUB, SLT) SHALL live in the shared package used by the decoder.
REQ-037 The package SHALL hold the requester-id width constant.
REQ-038 The existing alu module SHALL be instantiated once as the only sub-module; arbitration and output register are local logic.

Verification
REQ-039 Single add. req0 a=5, b=7, alucont=010, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
REQ-040 Contention. RR_INIT=0; both valid; req0 SUB 10-3, req1 OR 0xF0|0x0F; rsp_ready=1 -> results 7 (id 0) then 0xFF (id 1) on consecutive cycles.
REQ-041 Back-pressure. rsp_ready=0 for 3 cycles with result 12 held -> result and id stable, both ready=0; rsp_ready=1 -> next request accepted in that same cycle.
REQ-042 Wrap and SLT. ADD 0xFFFFFFFF+1 -> 0. SLT a=0xFFFFFFFE (-2), b=1 -> 1. SLT a=1, b=0xFFFFFFFE -> 0.
REQ-043 Reset mid-operation. Assert reset while rsp_valid=1 -> next cycle rsp_valid=0 and pointer=RR_INIT; a grant is possible the cycle after deassertion.
REQ-044 Fairness. Both valid for 8 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ALUCONT_W = 3;
    localparam int ID_W = 1;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ALUCONT_W-1:0] alucont_t;
    typedef logic [ID_W-1:0]      req_id_t;

    // ALU control codes understood by the decoder
    localparam alucont_t ALU_AND = 3'b000;
    localparam alucont_t ALU_OR  = 3'b001;
    localparam alucont_t ALU_ADD = 3'b010;
    localparam alucont_t ALU_SUB = 3'b110;
    localparam alucont_t ALU_SLT = 3'b111;

    // One operation as offered by a requester
    typedef struct packed {
        data_t    a;
        data_t    b;
        alucont_t alucont;
    } alu_op_t;

    localparam req_id_t REQ_ID_0 = 1'b0;
    localparam req_id_t REQ_ID_1 = 1'b1;

endpackage

// File: rtl/alu_arb_alu.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, SLT.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0]    a_i,
    input  logic [DATA_W-1:0]    b_i,
    input  logic [ALUCONT_W-1:0] alucont_i,
    output logic [DATA_W-1:0]    result_o
);

    data_t diff;

    // Decode the control code; SLT looks only at the sign of the wrapped difference
    always_comb begin
        diff     = a_i - b_i;
        result_o = '0;
        unique case (alucont_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = diff;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, diff[DATA_W-1]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one ALU between two requesters into one result register.
// Latency: 1 cycle from acceptance (reqN_ready) to rsp_valid.
// Backpressure: ready outputs drop while a result is held and rsp_ready=0.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_W-1:0]    req0_a,
    input  logic [DATA_W-1:0]    req0_b,
    input  logic [ALUCONT_W-1:0] req0_alucont,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_W-1:0]    req1_a,
    input  logic [DATA_W-1:0]    req1_b,
    input  logic [ALUCONT_W-1:0] req1_alucont,

    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [DATA_W-1:0]    rsp_result,
    input  logic                 rsp_ready
);

    logic    rsp_valid_q, rsp_valid_d;
    req_id_t rsp_id_q, rsp_id_d;
    data_t   rsp_result_q, rsp_result_d;
    req_id_t prio_q, prio_d;

    logic    stage_free;
    logic    grant;
    req_id_t win_id;
    alu_op_t op0, op1, win_op;
    data_t   alu_result;

    assign op0 = '{a: req0_a, b: req0_b, alucont: req0_alucont};
    assign op1 = '{a: req1_a, b: req1_b, alucont: req1_alucont};

    // Pick the winner: a lone requester wins, otherwise the priority pointer decides
    always_comb begin
        stage_free = !rsp_valid_q || rsp_ready;
        grant      = !reset && stage_free && (req0_valid || req1_valid);
        win_id     = REQ_ID_0;
        if (req0_valid && req1_valid) begin
            win_id = prio_q;
        end else if (req1_valid) begin
            win_id = REQ_ID_1;
        end
        win_op     = (win_id == REQ_ID_1) ? op1 : op0;
        req0_ready = grant && (win_id == REQ_ID_0);
        req1_ready = grant && (win_id == REQ_ID_1);
    end

    alu u_alu (
        .a_i       (win_op.a),
        .b_i       (win_op.b),
        .alucont_i (win_op.alucont),
        .result_o  (alu_result)
    );

    // Next state: a grant overwrites the stage (even while it is being delivered),
    // delivery alone empties it, and the pointer passes to the loser of each grant
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        prio_d       = prio_q;
        if (grant) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = win_id;
            rsp_result_d = alu_result;
            prio_d       = ~win_id;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Result stage and priority pointer; reset discards any held or in-flight operation
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= REQ_ID_0;
            rsp_result_q <= '0;
            prio_q       <= req_id_t'(RR_INIT);
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            prio_q       <= prio_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule
